// File: rtl/led_pkg.sv
// Shared constants and FSM encoding for the LED frame path.
package led_pkg;

    localparam int c_ch_per_board = 32;
    localparam int c_bpc_default  = 12;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_LATCH = 3'd4,
        S_DRQ   = 3'd5,
        S_GAP   = 3'd6
    } state_t;

endpackage

// File: rtl/led_bit_timer.sv
// Serial clock prescaler and bit counter: c_clkdiv cycles low, c_clkdiv cycles high per bit.
module led_bit_timer #(
    parameter int c_clkdiv = 4,
    parameter int c_bpc    = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic sclk,
    output logic bit_start,
    output logic word_done
);

    localparam int c_div_w = $clog2(c_clkdiv + 1);
    localparam int c_bit_w = $clog2(c_bpc + 1);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_clkdiv - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(c_bpc - 1);

    logic [c_div_w-1:0] div_cnt;
    logic [c_bit_w-1:0] bit_cnt;
    logic               phase_end;

    assign phase_end = en && (div_cnt == c_div_last);
    // Falling edge ends the current bit; the next bit's low phase starts after it.
    assign bit_start = phase_end && sclk;
    assign word_done = bit_start && (bit_cnt == c_bit_last);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
        end else if (en) begin
            if (phase_end) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
                if (sclk)
                    bit_cnt <= bit_cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_shifter.sv
// Frame refresher: streams the current colour buffer into the LED board chain.
// LED_SHIFTER_TESTPAT_EN adds i_test, which replaces buffer data with all-ones words.
module led_shifter
    import led_pkg::*;
#(
    parameter int c_ledboards = 30,
    parameter int c_bpc       = c_bpc_default,
    parameter int c_clkdiv    = 4,
    parameter int c_gap       = 4096,
    localparam int c_channels = c_ledboards * c_ch_per_board,
    localparam int c_addr_w   = $clog2(c_channels)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
`ifdef LED_SHIFTER_TESTPAT_EN
    input  logic                i_test,
`endif
    output logic [c_addr_w-1:0] o_raddr,
    input  logic [c_bpc-1:0]    i_data,
    output logic                o_sclk,
    output logic                o_sdata,
    output logic                o_latch,
    output logic                o_drq,
    output logic                o_busy
);

    localparam int c_lat_w = $clog2(c_clkdiv + 1);
    localparam int c_gap_w = $clog2(c_gap + 1);
    localparam logic [c_lat_w-1:0]  c_lat_last = c_lat_w'(c_clkdiv - 1);
    localparam logic [c_addr_w-1:0] c_top_addr = c_addr_w'(c_channels - 1);
    // DRQ cycle + GAP cycles + IDLE cycle span c_gap, so the next fetch lands c_gap cycles after o_drq.
    localparam logic [c_gap_w-1:0]  c_gap_load = c_gap_w'(c_gap - 2);

    state_t              state, state_nxt;
    logic [c_addr_w-1:0] raddr;
    logic [c_bpc-1:0]    shreg;
    logic [c_lat_w-1:0]  lat_cnt;
    logic [c_gap_w-1:0]  gap_cnt;
    logic                bit_start, word_done;
    logic [c_bpc-1:0]    load_word;

`ifdef LED_SHIFTER_TESTPAT_EN
    logic test_q;
    assign load_word = test_q ? {c_bpc{1'b1}} : i_data;
`else
    assign load_word = i_data;
`endif

    assign o_raddr = raddr;

    led_bit_timer #(
        .c_clkdiv (c_clkdiv),
        .c_bpc    (c_bpc)
    ) u_timer (
        .clk       (i_clk),
        .rst       (i_rst),
        .clr       (state == S_LOAD),
        .en        (state == S_SHIFT),
        .sclk      (o_sclk),
        .bit_start (bit_start),
        .word_done (word_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_en) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_SHIFT;
            S_SHIFT: if (word_done) state_nxt = (raddr == '0) ? S_LATCH : S_FETCH;
            S_LATCH: if (lat_cnt == c_lat_last) state_nxt = S_DRQ;
            S_DRQ:   state_nxt = S_GAP;
            S_GAP:   if (gap_cnt == c_gap_w'(1)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy  = 1'b0;
        o_sdata = 1'b0;
        o_latch = 1'b0;
        o_drq   = 1'b0;
        case (state)
            S_FETCH, S_LOAD: o_busy = 1'b1;
            S_SHIFT: begin
                o_busy  = 1'b1;
                o_sdata = shreg[c_bpc-1];
            end
            S_LATCH: begin
                o_busy  = 1'b1;
                o_latch = 1'b1;
            end
            S_DRQ: begin
                o_busy = 1'b1;
                o_drq  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            raddr   <= '0;
            shreg   <= '0;
            lat_cnt <= '0;
            gap_cnt <= '0;
`ifdef LED_SHIFTER_TESTPAT_EN
            test_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (i_en) begin
                    raddr  <= c_top_addr;
`ifdef LED_SHIFTER_TESTPAT_EN
                    test_q <= i_test;
`endif
                end
                S_LOAD: shreg <= load_word;
                S_SHIFT: begin
                    lat_cnt <= '0;
                    if (bit_start)
                        shreg <= shreg << 1;
                    if (word_done && raddr != '0)
                        raddr <= raddr - 1'b1;
                end
                S_LATCH: lat_cnt <= lat_cnt + 1'b1;
                S_DRQ:   gap_cnt <= c_gap_load;
                S_GAP:   gap_cnt <= gap_cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_shifter.sv
// Directed bench for led_shifter: 32 channels, c_clkdiv=2, c_gap=100, sync-RAM buffer model.
module tb_led_shifter;

    logic       clk = 1'b0;
    logic       i_rst, i_en, i_test;
    logic [4:0] o_raddr;
    logic [11:0] i_data;
    logic       o_sclk, o_sdata, o_latch, o_drq, o_busy;

    logic [11:0] mem [0:31];

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int nbits, latch_cyc, drq_cnt, overlap, busy_rises;
    int busy_start, drq_at, first_latch, last_latch, last_rise;
    logic prev_sclk = 1'b0, prev_busy = 1'b0;
    logic bits [0:511];

    always #5 clk = ~clk;

    led_shifter #(
        .c_ledboards (1),
        .c_clkdiv    (2),
        .c_gap       (100)
    ) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
`ifdef LED_SHIFTER_TESTPAT_EN
        .i_test  (i_test),
`endif
        .o_raddr (o_raddr),
        .i_data  (i_data),
        .o_sclk  (o_sclk),
        .o_sdata (o_sdata),
        .o_latch (o_latch),
        .o_drq   (o_drq),
        .o_busy  (o_busy)
    );

    always @(posedge clk) i_data <= mem[o_raddr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_trk();
        nbits = 0; latch_cyc = 0; drq_cnt = 0; overlap = 0; busy_rises = 0;
        first_latch = -1; last_latch = -1; last_rise = -1;
    endtask

    // One clock; observe outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (o_sclk && !prev_sclk) begin
            if (nbits < 512) bits[nbits] = o_sdata;
            nbits++;
            last_rise = cyc;
        end
        if (o_latch) begin
            latch_cyc++;
            if (first_latch < 0) first_latch = cyc;
            last_latch = cyc;
        end
        if (o_latch && o_sclk) overlap++;
        if (o_drq) begin
            drq_cnt++;
            drq_at = cyc;
        end
        if (o_busy && !prev_busy) begin
            busy_rises++;
            busy_start = cyc;
        end
        prev_sclk = o_sclk;
        prev_busy = o_busy;
    endtask

    task automatic run_until_drq(input string tag);
        int k = 0;
        while (drq_cnt == 0 && k < 3000) begin
            tick();
            k++;
        end
        check(tag, drq_cnt, 1);
    endtask

    function automatic int stream_errs();
        int e = 0;
        logic [11:0] w;
        for (int i = 0; i < 384; i++) begin
            w = 12'hA00 | 12'(31 - i / 12);
            if (bits[i] !== w[11 - i % 12]) e++;
        end
        return e;
    endfunction

    function automatic logic [11:0] word_at(input int base);
        logic [11:0] w = '0;
        for (int i = 0; i < 12; i++) w = {w[10:0], bits[base + i]};
        return w;
    endfunction

    initial begin
        int k;
        int ones;
        for (int a = 0; a < 32; a++) mem[a] = 12'hA00 | 12'(a);
        i_rst = 1'b1; i_en = 1'b1; i_test = 1'b0;
        clear_trk();

        // 1. Reset held with i_en=1
        repeat (3) tick();
        check("reset_outputs", {o_raddr, o_sclk, o_sdata, o_latch, o_drq, o_busy}, 0);
        clear_trk();
        i_rst = 1'b0;
        tick();
        check("first_raddr", o_raddr, 31);
        check("first_busy", o_busy, 1);

        // 2. Full frame stream; 1603 cycles from the i_en sampling cycle, one less from busy rise
        run_until_drq("frame1_drq");
        check("frame1_bits", nbits, 384);
        check("frame1_stream", stream_errs(), 0);
        check("frame1_first_word", word_at(0), 12'hA1F);
        check("frame1_last_word", word_at(372), 12'hA00);
        check("frame1_length", drq_at - busy_start, 1602);

        // 3. Latch and drq timing, then gap
        check("latch_cycles", latch_cyc, 2);
        check("latch_sclk_overlap", overlap, 0);
        check("latch_ends_before_drq", last_latch, drq_at - 1);
        check("latch_after_last_rise", (last_rise < first_latch), 1);
        tick();
        check("drq_one_cycle", {o_drq, o_busy}, 0);
        check("gap_raddr_zero", o_raddr, 0);
        clear_trk();
        k = 0;
        while (busy_rises == 0 && k < 300) begin tick(); k++; end
        check("gap_length", busy_start - drq_at, 100);
        check("frame2_raddr", o_raddr, 31);

        // 4. Drop i_en at bit 50: frame still completes, then stays idle
        k = 0;
        while (nbits < 50 && k < 2000) begin tick(); k++; end
        check("frame2_bit50", nbits, 50);
        i_en = 1'b0;
        run_until_drq("frame2_drq");
        check("frame2_bits", nbits, 384);
        check("frame2_stream", stream_errs(), 0);
        check("frame2_latch", latch_cyc, 2);
        busy_rises = 0;
        repeat (500) tick();
        check("idle_no_busy", busy_rises, 0);
        check("idle_busy_low", o_busy, 0);
        check("idle_one_drq", drq_cnt, 1);
        check("idle_one_latch", latch_cyc, 2);

        // 5. Reset during an sclk high phase
        i_en = 1'b1;
        clear_trk();
        k = 0;
        while (!(nbits >= 20 && o_sclk) && k < 2000) begin tick(); k++; end
        check("midrst_high_phase", o_sclk, 1);
        i_rst = 1'b1;
        tick();
        check("midrst_outputs", {o_raddr, o_sclk, o_sdata, o_latch, o_drq, o_busy}, 0);
        i_rst = 1'b0;
        clear_trk();
        run_until_drq("frame3_drq");
        check("frame3_full_before_drq", nbits, 384);
        check("frame3_stream", stream_errs(), 0);

`ifdef LED_SHIFTER_TESTPAT_EN
        // 6. Test pattern; toggling i_test mid-frame does not affect the running frame
        i_test = 1'b1;
        clear_trk();
        k = 0;
        while (nbits < 100 && k < 2000) begin tick(); k++; end
        i_test = 1'b0;
        run_until_drq("testpat_drq");
        ones = 0;
        for (int i = 0; i < 384; i++) if (bits[i] === 1'b1) ones++;
        check("testpat_ones", ones, 384);
        clear_trk();
        run_until_drq("post_testpat_drq");
        check("post_testpat_stream", stream_errs(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
